// File: rtl/armleocpu_defines.sv
// Shared decode constants: opcodes, instruction field bit ranges and the
// registered decode-to-execute bundle.
package armleocpu_defines;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;

  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;

  localparam int unsigned OPCODE_MSB = 6;
  localparam int unsigned OPCODE_LSB = 0;
  localparam int unsigned RD_MSB     = 11;
  localparam int unsigned RD_LSB     = 7;
  localparam int unsigned FUNCT3_MSB = 14;
  localparam int unsigned FUNCT3_LSB = 12;
  localparam int unsigned RS1_MSB    = 19;
  localparam int unsigned RS1_LSB    = 15;
  localparam int unsigned RS2_MSB    = 24;
  localparam int unsigned RS2_LSB    = 20;
  localparam int unsigned FUNCT7_MSB = 31;
  localparam int unsigned FUNCT7_LSB = 25;
  localparam int unsigned IMM12_MSB  = 31;
  localparam int unsigned IMM12_LSB  = 20;

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [6:0]        opcode;
    logic              is_op;
    logic              is_op_imm;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    logic [4:0]        shamt;
    logic [XLEN-1:0]   simm12;
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   rs1;
    logic [XLEN-1:0]   rs2;
  } d2e_bundle_t;

  function automatic logic [XLEN-1:0] sext_imm12(input logic [11:0] imm);
    return {{(XLEN-12){imm[11]}}, imm};
  endfunction

  // x0 reads zero; a same-cycle writeback to the index beats the regfile value.
  function automatic logic [XLEN-1:0] select_operand(
    input logic              fwd_en,
    input logic [REG_AW-1:0] idx,
    input logic [XLEN-1:0]   rdata,
    input logic              wb_write,
    input logic [REG_AW-1:0] wb_rd,
    input logic [XLEN-1:0]   wb_data
  );
    if (idx == '0)
      return '0;
    else if (fwd_en && wb_write && (wb_rd == idx))
      return wb_data;
    else
      return rdata;
  endfunction

endpackage

// File: rtl/armleocpu_decode_stage.sv
// Decode/operand-fetch stage: splits instruction fields, reads and forwards
// rs1/rs2, and hands a registered operand bundle to execute.
module armleocpu_decode_stage
  import armleocpu_defines::*;
#(
  parameter bit FORWARD_ENABLED = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,

  input  logic              f2d_valid,
  output logic              f2d_ready,
  input  logic [XLEN-1:0]   f2d_instr,
  input  logic [XLEN-1:0]   f2d_pc,

  output logic [REG_AW-1:0] rf_rs1_addr,
  output logic [REG_AW-1:0] rf_rs2_addr,
  input  logic [XLEN-1:0]   rf_rs1_rdata,
  input  logic [XLEN-1:0]   rf_rs2_rdata,

  input  logic              wb_write,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [XLEN-1:0]   wb_data,

  output logic              d2e_valid,
  input  logic              d2e_ready,
  output logic [XLEN-1:0]   d2e_pc,
  output logic [6:0]        d2e_opcode,
  output logic              d2e_is_op,
  output logic              d2e_is_op_imm,
  output logic [2:0]        d2e_funct3,
  output logic [6:0]        d2e_funct7,
  output logic [4:0]        d2e_shamt,
  output logic [XLEN-1:0]   d2e_simm12,
  output logic [REG_AW-1:0] d2e_rd,
  output logic [XLEN-1:0]   d2e_rs1,
  output logic [XLEN-1:0]   d2e_rs2
);

  logic              valid_q, valid_d;
  d2e_bundle_t       bundle_q, bundle_d;
  logic [REG_AW-1:0] rs1_idx_q, rs1_idx_d;
  logic [REG_AW-1:0] rs2_idx_q, rs2_idx_d;
  logic              accept_c;
  logic              hold_c;
  logic [6:0]        opcode_c;

  assign f2d_ready   = !valid_q || d2e_ready;
  assign accept_c    = f2d_valid && f2d_ready && !flush;
  assign hold_c      = valid_q && !d2e_ready;
  assign rf_rs1_addr = f2d_instr[RS1_MSB:RS1_LSB];
  assign rf_rs2_addr = f2d_instr[RS2_MSB:RS2_LSB];
  assign opcode_c    = f2d_instr[OPCODE_MSB:OPCODE_LSB];

  // Next bundle: load on accept, otherwise refresh held operands from writeback.
  always_comb begin
    bundle_d  = bundle_q;
    rs1_idx_d = rs1_idx_q;
    rs2_idx_d = rs2_idx_q;
    valid_d   = valid_q;

    if (accept_c) begin
      bundle_d.pc        = f2d_pc;
      bundle_d.opcode    = opcode_c;
      bundle_d.is_op     = (opcode_c == OPCODE_OP);
      bundle_d.is_op_imm = (opcode_c == OPCODE_OP_IMM);
      bundle_d.funct3    = f2d_instr[FUNCT3_MSB:FUNCT3_LSB];
      bundle_d.funct7    = f2d_instr[FUNCT7_MSB:FUNCT7_LSB];
      bundle_d.shamt     = f2d_instr[RS2_MSB:RS2_LSB];
      bundle_d.simm12    = sext_imm12(f2d_instr[IMM12_MSB:IMM12_LSB]);
      bundle_d.rd        = f2d_instr[RD_MSB:RD_LSB];
      bundle_d.rs1       = select_operand(FORWARD_ENABLED, rf_rs1_addr, rf_rs1_rdata,
                                          wb_write, wb_rd, wb_data);
      bundle_d.rs2       = select_operand(FORWARD_ENABLED, rf_rs2_addr, rf_rs2_rdata,
                                          wb_write, wb_rd, wb_data);
      rs1_idx_d          = rf_rs1_addr;
      rs2_idx_d          = rf_rs2_addr;
    end else if (hold_c && wb_write && (wb_rd != '0)) begin
      // Held operands track writeback unconditionally so they never go stale.
      if (wb_rd == rs1_idx_q)
        bundle_d.rs1 = wb_data;
      if (wb_rd == rs2_idx_q)
        bundle_d.rs2 = wb_data;
    end

    if (flush)
      valid_d = 1'b0;
    else if (accept_c)
      valid_d = 1'b1;
    else if (d2e_ready)
      valid_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      bundle_q  <= '0;
      rs1_idx_q <= '0;
      rs2_idx_q <= '0;
    end else begin
      valid_q   <= valid_d;
      bundle_q  <= bundle_d;
      rs1_idx_q <= rs1_idx_d;
      rs2_idx_q <= rs2_idx_d;
    end
  end

  assign d2e_valid     = valid_q;
  assign d2e_pc        = bundle_q.pc;
  assign d2e_opcode    = bundle_q.opcode;
  assign d2e_is_op     = bundle_q.is_op;
  assign d2e_is_op_imm = bundle_q.is_op_imm;
  assign d2e_funct3    = bundle_q.funct3;
  assign d2e_funct7    = bundle_q.funct7;
  assign d2e_shamt     = bundle_q.shamt;
  assign d2e_simm12    = bundle_q.simm12;
  assign d2e_rd        = bundle_q.rd;
  assign d2e_rs1       = bundle_q.rs1;
  assign d2e_rs2       = bundle_q.rs2;

endmodule
